// File: rtl/rc5_decryptor_if.sv
// Request/response bundle for the RC5-16 decryption engine.
// The requester drives start, num_rounds, key and d_in; the engine returns
// d_out together with the busy/done status.
interface rc5_decryptor_if;
    logic         start;
    logic [4:0]   num_rounds;
    logic [127:0] key;
    logic [31:0]  d_in;
    logic [31:0]  d_out;
    logic         busy;
    logic         done;

    modport master (
        output start, num_rounds, key, d_in,
        input  d_out, busy, done
    );

    modport slave (
        input  start, num_rounds, key, d_in,
        output d_out, busy, done
    );
endinterface

// File: rtl/rc5_decryptor.sv
// RC5-16/r/16 decryption engine: 32-bit block, 16-bit words, 128-bit key,
// 0..31 rounds. It expands the key itself, then runs one inverse round per clock.
//
// Optional feature: define RC5_KEY_CACHE_EN to keep the last completed key
// expansion. A start with the same key and saturated round count then skips
// INIT and MIX and goes directly to the rounds.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; inputs are latched when start is accepted
// S_INIT  | t cycles filling S[i] = P + i*Q
// S_MIX   | 3*max(t,8) cycles mixing the key words into S
// S_ROUND | r cycles of inverse rounds, k counts from r down to 1
// S_FINAL | removes S[0]/S[1] and loads d_out
// S_DONE  | one-cycle done pulse, then back to idle
module rc5_decryptor #(
    parameter int          MAX_ROUNDS = 31,
    parameter logic [15:0] P_CONST    = 16'hB7E1,
    parameter logic [15:0] Q_CONST    = 16'h9E37
) (
    input  logic           clk,
    input  logic           rst,
    rc5_decryptor_if.slave bus
);
    localparam int S_WORDS = 2 * (MAX_ROUNDS + 1);
    localparam int S_AW    = $clog2(S_WORDS);
    localparam int TW      = S_AW + 1;
    // The counter must hold 3*max(t,8)-1, which is at most 191.
    localparam int CW      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MIX,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [15:0]     r_s [S_WORDS];
    logic [15:0]     r_l [8];

    logic [4:0]      r_r;
    logic [4:0]      r_k;
    logic [TW-1:0]   r_t;
    logic [CW-1:0]   r_cnt;
    logic [S_AW-1:0] r_i;
    logic [2:0]      r_j;
    logic [15:0]     r_sval;
    logic [15:0]     r_ma;
    logic [15:0]     r_mb;
    logic [15:0]     r_da;
    logic [15:0]     r_db;
    logic [31:0]     r_d_out;

    logic            w_accept;
    logic            w_hit;
    logic [4:0]      w_r_sat;
    logic [TW-1:0]   w_t;
    logic [CW-1:0]   w_mix_len;
    logic            w_init_tc;
    logic            w_mix_tc;
    logic            w_round_tc;
    logic            w_i_wrap;
    logic [15:0]     w_mix_a;
    logic [15:0]     w_mix_ab;
    logic [15:0]     w_mix_b;
    logic [15:0]     w_rnd_a;
    logic [15:0]     w_rnd_b;
    logic [S_AW-1:0] w_idx_even;
    logic [S_AW-1:0] w_idx_odd;

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] w_d;
        w_d = {x, x} << n;
        return w_d[31:16];
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] w_d;
        w_d = {x, x} >> n;
        return w_d[15:0];
    endfunction

    // Request decode, round-count saturation and phase terminal counts.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && bus.start;
        w_r_sat    = (int'(bus.num_rounds) > MAX_ROUNDS) ? 5'(MAX_ROUNDS) : bus.num_rounds;
        w_t        = TW'(2 * (int'(w_r_sat) + 1));
        w_mix_len  = CW'(3 * ((int'(r_t) > 8) ? int'(r_t) : 8) - 1);
        w_init_tc  = (r_cnt == '0);
        w_mix_tc   = (r_cnt == '0);
        w_round_tc = (r_k == 5'd1);
        w_i_wrap   = (r_i == S_AW'(r_t - TW'(1)));
        w_idx_even = S_AW'({r_k, 1'b0});
        w_idx_odd  = S_AW'({r_k, 1'b1});
    end

    // One key-mixing step; B uses the freshly computed A.
    always_comb begin
        w_mix_a  = rotl16(r_s[r_i] + r_ma + r_mb, 4'd3);
        w_mix_ab = w_mix_a + r_mb;
        w_mix_b  = rotl16(r_l[r_j] + w_mix_ab, w_mix_ab[3:0]);
    end

    // One inverse round; A uses the freshly computed B.
    always_comb begin
        w_rnd_b = rotr16(r_db - r_s[w_idx_odd], r_da[3:0]) ^ r_da;
        w_rnd_a = rotr16(r_da - r_s[w_idx_even], w_rnd_b[3:0]) ^ w_rnd_b;
    end

`ifdef RC5_KEY_CACHE_EN
    logic         r_c_valid;
    logic [127:0] r_c_key;
    logic [4:0]   r_c_r;

    assign w_hit = r_c_valid && (bus.key == r_c_key) && (w_r_sat == r_c_r);

    // Cache tag: invalidated when a new expansion starts, validated when it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_valid <= 1'b0;
            r_c_key   <= '0;
            r_c_r     <= '0;
        end else if (w_accept && !w_hit) begin
            r_c_valid <= 1'b0;
            r_c_key   <= bus.key;
            r_c_r     <= w_r_sat;
        end else if ((r_state == S_MIX) && w_mix_tc) begin
            r_c_valid <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_next    = r_state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.d_out = r_d_out;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_hit) begin
                        w_next = (w_r_sat == 5'd0) ? S_FINAL : S_ROUND;
                    end else begin
                        w_next = S_INIT;
                    end
                end
            end
            S_INIT: begin
                bus.busy = 1'b1;
                if (w_init_tc) begin
                    w_next = S_MIX;
                end
            end
            S_MIX: begin
                bus.busy = 1'b1;
                if (w_mix_tc) begin
                    w_next = (r_r == 5'd0) ? S_FINAL : S_ROUND;
                end
            end
            S_ROUND: begin
                bus.busy = 1'b1;
                if (w_round_tc) begin
                    w_next = S_FINAL;
                end
            end
            S_FINAL: begin
                bus.busy = 1'b1;
                w_next   = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Counters, working A/B pairs and the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r     <= '0;
            r_k     <= '0;
            r_t     <= '0;
            r_cnt   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_sval  <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_da    <= '0;
            r_db    <= '0;
            r_d_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_r    <= w_r_sat;
                        r_k    <= w_r_sat;
                        r_t    <= w_t;
                        r_cnt  <= CW'(w_t - TW'(1));
                        r_i    <= '0;
                        r_sval <= P_CONST;
                        r_da   <= bus.d_in[15:0];
                        r_db   <= bus.d_in[31:16];
                    end
                end
                S_INIT: begin
                    r_sval <= r_sval + Q_CONST;
                    r_ma   <= '0;
                    r_mb   <= '0;
                    r_j    <= '0;
                    if (w_init_tc) begin
                        r_i   <= '0;
                        r_cnt <= w_mix_len;
                    end else begin
                        r_i   <= r_i + S_AW'(1);
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_MIX: begin
                    r_ma  <= w_mix_a;
                    r_mb  <= w_mix_b;
                    r_i   <= w_i_wrap ? '0 : r_i + S_AW'(1);
                    r_j   <= r_j + 3'd1;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_ROUND: begin
                    r_da <= w_rnd_a;
                    r_db <= w_rnd_b;
                    r_k  <= r_k - 5'd1;
                end
                S_FINAL: begin
                    r_d_out <= {r_db - r_s[1], r_da - r_s[0]};
                end
                default: begin
                end
            endcase
        end
    end

    // S table and key-word copy; contents are meaningless after reset, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int n = 0; n < 8; n++) begin
                r_l[n] <= bus.key[16*n +: 16];
            end
        end
        if (r_state == S_INIT) begin
            r_s[r_i] <= r_sval;
        end
        if (r_state == S_MIX) begin
            r_s[r_i] <= w_mix_a;
            r_l[r_j] <= w_mix_b;
        end
    end
endmodule
